fetch_queue: RTL

Parametrised instruction-fetch front end: issues line-sized memory reads on the system bus request/response channels and lands the returned beats in a circular byte buffer. It presents a byte window plus valid count and window address to the decoder, and retires the bytes the decoder consumes. It is the next generation of the core fetch path. New capabilities over the previous one:
- byte-granular entry skip
- decoder-visible byte count and RIP
- redirect (branch/flush) that drops in-flight lines

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_ring.sv | 60 ++++++
 rtl/fetch_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      XFER = 2'd3
   } fetch_state_t;

   // Tag layout: {opcode[2:0], space[1:0], id[7:0]}
   localparam logic [2:0]  TAG_OP_READ      = 3'b001;
   localparam logic [1:0]  TAG_SPACE_MEMORY = 2'b00;
   localparam logic [12:0] FETCH_TAG        = {TAG_OP_READ, TAG_SPACE_MEMORY, 8'b0};

   function automatic int clog2w(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/fetch_ring.sv
// Circular byte buffer: beat-slice write port, wrapped WINDOW-byte read port.
module fetch_ring
   import fetch_pkg::*;
#(
   parameter int BUF_BYTES  = 128,
   parameter int BEAT_BYTES = 8,
   parameter int WINDOW     = 15,
   localparam int AW = clog2w(BUF_BYTES),
   localparam int PW = AW + 1,
   localparam int CW = clog2w(BUF_BYTES + 1),
   localparam int SW = clog2w(BEAT_BYTES),
   localparam int NW = clog2w(BEAT_BYTES + 1),
   localparam int KW = clog2w(WINDOW + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [SW-1:0]           wr_start,
   input  logic [NW-1:0]           wr_count,
   input  logic [BEAT_BYTES*8-1:0] wr_data,
   input  logic [KW-1:0]           consume,
   output logic [WINDOW*8-1:0]     rd_data,
   output logic [CW-1:0]           count
);

   logic [7:0]    mem [BUF_BYTES];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // One extra pointer bit distinguishes a full ring from an empty one.
   assign count = CW'(wr_ptr - rd_ptr);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(wr_count);
         rd_ptr <= rd_ptr + PW'(consume);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !clear) begin
         for (int j = 0; j < BEAT_BYTES; j++) begin
            if (j >= int'(wr_start) && j < int'(wr_start) + int'(wr_count))
               mem[AW'(wr_ptr[AW-1:0] + AW'(j - int'(wr_start)))] <= wr_data[8*j +: 8];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < WINDOW; i++) begin
         if (CW'(i) < count)
            rd_data[8*i +: 8] = mem[AW'(rd_ptr[AW-1:0] + AW'(i))];
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: line requests, skip/drop handling, decoder window.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int BUF_BYTES  = 128,
   parameter int LINE_BYTES = 64,
   parameter int BEAT_BYTES = 8,
   parameter int WINDOW     = 15,
   parameter int TAG_W      = 13,
   localparam int CW = clog2w(BUF_BYTES + 1),
   localparam int KW = clog2w(WINDOW + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [63:0]             entry,
   output logic                    req_cyc,
   input  logic                    req_ack,
   output logic [63:0]             req_addr,
   output logic [TAG_W-1:0]        req_tag,
   input  logic                    resp_cyc,
   output logic                    resp_ack,
   input  logic [BEAT_BYTES*8-1:0] resp_data,
   input  logic                    redirect_valid,
   input  logic [63:0]             redirect_rip,
   output logic [WINDOW*8-1:0]     win_bytes,
   output logic [CW-1:0]           win_count,
   output logic [63:0]             win_rip,
   input  logic [KW-1:0]           consume,
   output logic                    idle,
   output logic [1:0]              fsm_state
);

   localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
   localparam int BCW    = clog2w(NBEATS + 1);
   localparam int LOW    = clog2w(LINE_BYTES);
   localparam int SW     = clog2w(BEAT_BYTES);
   localparam int NW     = clog2w(BEAT_BYTES + 1);
   localparam logic [63:0] LINE_MASK = 64'(LINE_BYTES - 1);

   fetch_state_t   state, state_next;
   logic [BCW-1:0] beat_cnt;
   logic [63:0]    fetch_rip;
   logic [LOW-1:0] skip;
   logic           drop;
   logic           launch, beat_in, line_end;
   logic [SW-1:0]  wr_start;
   logic [NW-1:0]  wr_count;
   int             beat_off;
   int             skip_eff;

   // Handshakes: a request transfers on a cycle with req_cyc && req_ack, and
   // req_cyc/req_addr hold until then; every resp_cyc beat is accepted at once.
   assign req_cyc   = (state == REQ);
   assign req_tag   = TAG_W'(FETCH_TAG);
   assign resp_ack  = resp_cyc;
   assign idle      = (state == IDLE) && (win_count == '0);
   assign fsm_state = state;

   assign launch   = (state == IDLE) && !redirect_valid &&
                     (win_count <= CW'(BUF_BYTES - LINE_BYTES));
   assign beat_in  = resp_cyc && (state == WAIT || state == XFER);
   assign line_end = beat_in && (beat_cnt == BCW'(NBEATS - 1));

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (launch)  state_next = REQ;
         REQ:  if (req_ack) state_next = WAIT;
         WAIT, XFER: begin
            if (line_end)     state_next = IDLE;
            else if (beat_in) state_next = XFER;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bytes below the skip point of the first line after a restart are discarded.
   always_comb begin
      beat_off = int'(beat_cnt) * BEAT_BYTES;
      skip_eff = int'(skip);
      wr_start = '0;
      wr_count = '0;
      if (beat_in && !drop && !redirect_valid) begin
         if (skip_eff >= beat_off + BEAT_BYTES) begin
            wr_count = '0;
         end else if (skip_eff > beat_off) begin
            wr_start = SW'(skip_eff - beat_off);
            wr_count = NW'(BEAT_BYTES - (skip_eff - beat_off));
         end else begin
            wr_count = NW'(BEAT_BYTES);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         req_addr  <= '0;
         drop      <= 1'b0;
         fetch_rip <= entry & ~LINE_MASK;
         skip      <= entry[LOW-1:0];
         win_rip   <= entry;
      end else begin
         state <= state_next;
         if (beat_in)
            beat_cnt <= line_end ? '0 : beat_cnt + BCW'(1);
         if (launch)
            req_addr <= fetch_rip;
         if (redirect_valid) begin
            win_rip   <= redirect_rip;
            fetch_rip <= redirect_rip & ~LINE_MASK;
            skip      <= redirect_rip[LOW-1:0];
            // A line ending on this very edge has nothing left to drop.
            drop      <= (state != IDLE) && !line_end;
         end else begin
            win_rip <= win_rip + 64'(consume);
            if (line_end) begin
               drop <= 1'b0;
               if (!drop) begin
                  fetch_rip <= fetch_rip + 64'(LINE_BYTES);
                  skip      <= '0;
               end
            end
         end
      end
   end

   fetch_ring #(
      .BUF_BYTES (BUF_BYTES),
      .BEAT_BYTES(BEAT_BYTES),
      .WINDOW    (WINDOW)
   ) u_ring (
      .clk     (clk),
      .reset   (reset),
      .clear   (redirect_valid),
      .wr_start(wr_start),
      .wr_count(wr_count),
      .wr_data (resp_data),
      .consume (consume),
      .rd_data (win_bytes),
      .count   (win_count)
   );

   a_consume_range: assert property (@(posedge clk) disable iff (reset)
      int'(consume) <= ((int'(win_count) < WINDOW) ? int'(win_count) : WINDOW));

   a_resp_in_state: assert property (@(posedge clk) disable iff (reset)
      !(resp_cyc && (state == IDLE || state == REQ)));

endmodule
